ps2_keyboard_rx: RTL and testbench

PS/2 device-to-host receiver for the alarm-clock keypad path. It samples the open-collector PS2C/PS2D lines and deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop). It presents each good byte on ps2_key_code with a one-cycle strobe. Its ps2_key_code output is interface-compatible with the keypad-code consumer downstream, so it drops in where the simulation keyboard model is used today.

---
 rtl/ps2_keyboard_rx.sv | 151 +++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: 2-FF synchronizers, PS2C glitch filter, 11-bit frame deserializer.
// Optional break-prefix (8'hF0) decoding is compiled in with `define PS2_RX_BREAK_DECODE_EN.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       ck,
    input  logic       reset_n,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic [7:0] ps2_key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       frame_err,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [3:0]    FILT_LAST = 4'(FILTER_LEN - 1);

    logic          c_s1, c_s2, d_s1, d_s2;
    logic          filt;
    logic [3:0]    fcnt;
    logic          fall;
    logic [1:0]    state;
    logic [3:0]    bcnt;
    logic [8:0]    shreg;
    logic [TW-1:0] tcnt;

    logic stop_fall, frame_good, timeout_hit, bad_start, err_now, is_break, emit_now;

    assign dbg_state = state;

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
        end else begin
            c_s1 <= PS2C;
            c_s2 <= c_s1;
            d_s1 <= PS2D;
            d_s2 <= d_s1;
        end
    end

    // fcnt counts consecutive samples that disagree with filt; any agreeing sample restarts it.
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            filt <= 1'b1;
            fcnt <= 4'd0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (c_s2 == filt) begin
                fcnt <= 4'd0;
            end else if (fcnt == FILT_LAST) begin
                filt <= c_s2;
                fcnt <= 4'd0;
                fall <= ~c_s2;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // The frame verdict is taken on the stop-bit fall so the strobes are visible during CHECK.
    assign stop_fall   = (state == SHIFT) && fall && (bcnt == 4'd9);
    assign frame_good  = stop_fall && d_s2 && (^shreg);
    assign timeout_hit = (state == SHIFT) && !fall && (tcnt == TO_LAST);
    assign bad_start   = (state == IDLE) && fall && d_s2;
    assign err_now     = bad_start || timeout_hit || (stop_fall && !frame_good);
    assign emit_now    = frame_good && !is_break;

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bcnt         <= 4'd0;
            shreg        <= 9'd0;
            tcnt         <= '0;
            ps2_key_code <= 8'h00;
            key_valid    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            key_valid <= emit_now;
            frame_err <= err_now;
            if (emit_now)
                ps2_key_code <= shreg[7:0];
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (fall && !d_s2) begin
                        shreg <= 9'd0;
                        bcnt  <= 4'd0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        tcnt <= '0;
                        if (bcnt == 4'd9) begin
                            state <= CHECK;
                        end else begin
                            shreg[bcnt] <= d_s2;
                            bcnt        <= bcnt + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    tcnt  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PS2_RX_BREAK_DECODE_EN
    logic release_pending;

    assign is_break = frame_good && (shreg[7:0] == 8'hF0);

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            release_pending <= 1'b0;
            key_release     <= 1'b0;
        end else begin
            key_release <= emit_now && release_pending;
            if (err_now || emit_now)
                release_pending <= 1'b0;
            else if (is_break)
                release_pending <= 1'b1;
        end
    end
`else
    assign is_break    = 1'b0;
    assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: bit-level PS/2 driver, expected-event queue, monitor.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int PIN_TO_FALL    = 2 + FILTER_LEN;

    logic       ck;
    logic       reset_n;
    logic       PS2C;
    logic       PS2D;
    logic [7:0] ps2_key_code;
    logic       key_valid;
    logic       key_release;
    logic       frame_err;
    logic [1:0] dbg_state;

    ps2_keyboard_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .ck          (ck),
        .reset_n     (reset_n),
        .PS2C        (PS2C),
        .PS2D        (PS2D),
        .ps2_key_code(ps2_key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .frame_err   (frame_err),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial ck = 1'b0;
    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard: {frame_err, key_release, ps2_key_code}
    logic [9:0] exp_q[$];
    logic [7:0] model_code = 8'h00;
    logic       model_pending = 1'b0;
    logic [9:0] mon_obs, mon_exp;
    int         last_fall_cyc = 0;
    int         last_err_cyc = 0;

    task automatic model_err();
        exp_q.push_back({1'b1, 1'b0, model_code});
        model_pending = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] code, input logic good);
        if (!good) begin
            model_err();
        end else begin
`ifdef PS2_RX_BREAK_DECODE_EN
            if (code == 8'hF0) begin
                model_pending = 1'b1;
            end else begin
                exp_q.push_back({1'b0, model_pending, code});
                model_code    = code;
                model_pending = 1'b0;
            end
`else
            exp_q.push_back({1'b0, 1'b0, code});
            model_code = code;
`endif
        end
    endtask

    always @(negedge ck) begin
        if (reset_n && (key_valid || frame_err)) begin
            mon_obs = {frame_err, key_release, ps2_key_code};
            check("strobe_excl", 32'(key_valid & frame_err), 32'd0);
            if (frame_err)
                last_err_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(mon_obs), 32'h3FF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", 32'(mon_obs), 32'(mon_exp));
            end
        end
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic send_bit(input logic b);
        PS2D = b;
        wait_cyc(6);
        PS2C = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(12);
        PS2C = 1'b1;
        wait_cyc(6);
    endtask

    task automatic glitch();
        PS2C = 1'b0;
        wait_cyc(2);
        PS2C = 1'b1;
        wait_cyc(8);
    endtask

    // glitch_at: bit index before which a 2-cycle PS2C glitch is inserted (-1 none, 0 = in IDLE)
    task automatic send_frame(input logic [7:0] code, input logic par_ok, input logic stop,
                              input int glitch_at);
        logic [10:0] bits;
        logic        par;
        par  = par_ok ? ~(^code) : (^code);
        bits = {stop, par, code, 1'b0};
        model_frame(code, par_ok && stop);
        for (int i = 0; i < 11; i++) begin
            if (i == glitch_at)
                glitch();
            send_bit(bits[i]);
        end
        PS2D = 1'b1;
        wait_cyc(20);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            wait_cyc(1);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        PS2C    = 1'b1;
        PS2D    = 1'b1;

        // reset held while the keyboard clock toggles
        for (int i = 0; i < 6; i++) begin
            PS2D = i[0];
            PS2C = ~PS2C;
            wait_cyc(7);
        end
        PS2C = 1'b1;
        PS2D = 1'b1;
        wait_cyc(8);
        check("rst_code", 32'(ps2_key_code), 32'h00);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_release", 32'(key_release), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        wait_cyc(5);

        // first frame after reset, then parity error, then recovery
        send_frame(8'h69, 1'b1, 1'b1, -1);
        send_frame(8'h69, 1'b0, 1'b1, -1);
        send_frame(8'h7B, 1'b1, 1'b1, -1);
        drain();
        check("code_7b", 32'(ps2_key_code), 32'h7B);

        // break sequence
        send_frame(8'h69, 1'b1, 1'b1, -1);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        send_frame(8'h69, 1'b1, 1'b1, -1);
        drain();

        // timeout: start bit + 3 data bits, then the line idles high
        model_err();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        PS2D = 1'b1;
        wait_cyc(TIMEOUT_CYCLES + 60);
        drain();
        check("timeout_latency", 32'(last_err_cyc - last_fall_cyc),
              32'(PIN_TO_FALL + TIMEOUT_CYCLES));
        send_frame(8'h7A, 1'b1, 1'b1, -1);
        drain();

        // glitches in IDLE and mid-frame
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        send_frame(8'hA5, 1'b1, 1'b1, 5);
        drain();

        // bad start and bad stop
        model_err();
        send_bit(1'b1);
        wait_cyc(20);
        send_frame(8'h33, 1'b1, 1'b0, -1);
        drain();
        check("hold_after_stop_err", 32'(ps2_key_code), 32'(model_code));

        // break prefix cancelled by an error
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        send_frame(8'h12, 1'b0, 1'b1, -1);
        send_frame(8'h12, 1'b1, 1'b1, -1);
        drain();

        // reset mid-frame drops the partial frame
        send_bit(1'b0);
        send_bit(1'b1);
        reset_n = 1'b0;
        wait_cyc(3);
        check("midrst_code", 32'(ps2_key_code), 32'h00);
        PS2C = 1'b1;
        PS2D = 1'b1;
        model_code    = 8'h00;
        model_pending = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(5);
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        drain();

        // random good and bad frames
        for (int i = 0; i < 8; i++) begin
            logic [7:0] code;
            code = 8'($urandom_range(0, 255));
            send_frame(code, ($urandom_range(0, 3) != 0), 1'b1, -1);
        end
        drain();

        wait_cyc(20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
